// File: rtl/video_pattern_gen.sv
// Synthetic video source: programmable-timing 8-bit luminance frames (ramp, checkerboard, solid).
// Define VIDEO_PATGEN_MOVE_EN to add a per-frame scrolling offset to the horizontal ramp.
module video_pattern_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_BLANK  = 160,
  parameter int V_SYNC   = 2,
  parameter int V_BACK   = 20,
  parameter int V_ACTIVE = 480,
  parameter int V_FRONT  = 10,
  parameter int CLK_DIV  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] mode,
  input  logic [7:0] level,
  output logic       per_frame_vsync,
  output logic       per_frame_href,
  output logic       per_frame_clken,
  output logic [7:0] per_img_Y,
  output logic       frame_done
);

  localparam logic [11:0] H_LAST    = 12'(H_ACTIVE + H_BLANK - 1);
  localparam logic [11:0] H_ACT     = 12'(H_ACTIVE);
  localparam logic [11:0] VS_LAST   = 12'(V_SYNC - 1);
  localparam logic [11:0] VB_LAST   = 12'(V_BACK - 1);
  localparam logic [11:0] VA_LAST   = 12'(V_ACTIVE - 1);
  localparam logic [11:0] VF_LAST   = 12'(V_FRONT - 1);
  localparam logic [3:0]  DIV_LAST  = 4'(CLK_DIV - 1);
  localparam bit          HAS_BACK  = (V_BACK > 0);
  localparam bit          HAS_FRONT = (V_FRONT > 0);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VSYNC,
    ST_VBACK,
    ST_ACTIVE,
    ST_VFRONT
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  div_q, div_d;
  logic [11:0] h_q, h_d;
  logic [11:0] line_q, line_d;
  logic [1:0]  mode_q, mode_d;
  logic [7:0]  level_q, level_d;
  logic        vsync_q, vsync_d;
  logic        href_q, href_d;
  logic        clken_q, clken_d;
  logic        done_q, done_d;
  logic [7:0]  y_q, y_d;

  logic        tick_s;
  logic        line_end_s;
  logic        state_last_s;
  logic        frame_end_s;
  logic [11:0] line_last_s;
  logic [7:0]  offset_s;
  logic [7:0]  pix_s;

`ifdef VIDEO_PATGEN_MOVE_EN
  logic [7:0] offset_q, offset_d;

  // Scroll offset advances once per completed frame
  always_comb begin
    if (frame_end_s) begin
      offset_d = offset_q + 8'd1;
    end else begin
      offset_d = offset_q;
    end
  end

  // Offset register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= 8'd0;
    end else begin
      offset_q <= offset_d;
    end
  end

  assign offset_s = offset_q;
`else
  assign offset_s = 8'd0;
`endif

  // Pixel tick and line/state/frame boundary detection
  always_comb begin
    tick_s     = (state_q != ST_IDLE) && (div_q == DIV_LAST);
    line_end_s = tick_s && (h_q == H_LAST);
    case (state_q)
      ST_VSYNC:  line_last_s = VS_LAST;
      ST_VBACK:  line_last_s = VB_LAST;
      ST_ACTIVE: line_last_s = VA_LAST;
      ST_VFRONT: line_last_s = VF_LAST;
      default:   line_last_s = 12'd0;
    endcase
    state_last_s = line_end_s && (line_q == line_last_s);
    frame_end_s  = state_last_s &&
                   ((state_q == ST_VFRONT) || ((state_q == ST_ACTIVE) && !HAS_FRONT));
  end

  // Next state: divider, pixel/line counters, FSM and frame-start latch
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    h_d     = h_q;
    line_d  = line_q;
    mode_d  = mode_q;
    level_d = level_q;
    if (state_q == ST_IDLE) begin
      div_d  = 4'd0;
      h_d    = 12'd0;
      line_d = 12'd0;
      if (en) begin
        state_d = ST_VSYNC;
        mode_d  = mode;
        level_d = level;
      end else begin
        state_d = ST_IDLE;
      end
    end else if (tick_s) begin
      div_d = 4'd0;
      h_d   = line_end_s ? 12'd0 : (h_q + 12'd1);
      if (state_last_s) begin
        line_d = 12'd0;
        case (state_q)
          ST_VSYNC:  state_d = HAS_BACK ? ST_VBACK : ST_ACTIVE;
          ST_VBACK:  state_d = ST_ACTIVE;
          ST_ACTIVE: state_d = HAS_FRONT ? ST_VFRONT : ST_IDLE;
          ST_VFRONT: state_d = ST_IDLE;
          default:   state_d = ST_IDLE;
        endcase
      end else if (line_end_s) begin
        line_d = line_q + 12'd1;
      end else begin
        line_d = line_q;
      end
      // en is only honoured at the frame boundary; mode/level are frozen for the new frame
      if (frame_end_s && en) begin
        state_d = ST_VSYNC;
        mode_d  = mode;
        level_d = level;
      end else begin
        mode_d  = mode_q;
        level_d = level_q;
      end
    end else begin
      div_d = div_q + 4'd1;
    end
  end

  // Luminance for the current position
  always_comb begin
    case (mode_q)
      2'd0:    pix_s = h_q[7:0] + offset_s;
      2'd1:    pix_s = line_q[7:0];
      2'd2:    pix_s = (h_q[3] ^ line_q[3]) ? 8'd255 : 8'd0;
      default: pix_s = level_q;
    endcase
  end

  // Output stream: refreshed on each tick, held for the rest of the pixel period
  always_comb begin
    vsync_d = vsync_q;
    href_d  = href_q;
    y_d     = y_q;
    clken_d = 1'b0;
    done_d  = 1'b0;
    if (state_q == ST_IDLE) begin
      vsync_d = 1'b0;
      href_d  = 1'b0;
      y_d     = 8'd0;
    end else if (tick_s) begin
      clken_d = 1'b1;
      vsync_d = (state_q == ST_VSYNC);
      href_d  = (state_q == ST_ACTIVE) && (h_q < H_ACT);
      y_d     = href_d ? pix_s : 8'd0;
      done_d  = frame_end_s;
    end else begin
      clken_d = 1'b0;
      done_d  = 1'b0;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      div_q   <= 4'd0;
      h_q     <= 12'd0;
      line_q  <= 12'd0;
      mode_q  <= 2'd0;
      level_q <= 8'd0;
      vsync_q <= 1'b0;
      href_q  <= 1'b0;
      clken_q <= 1'b0;
      done_q  <= 1'b0;
      y_q     <= 8'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      h_q     <= h_d;
      line_q  <= line_d;
      mode_q  <= mode_d;
      level_q <= level_d;
      vsync_q <= vsync_d;
      href_q  <= href_d;
      clken_q <= clken_d;
      done_q  <= done_d;
      y_q     <= y_d;
    end
  end

  assign per_frame_vsync = vsync_q;
  assign per_frame_href  = href_q;
  assign per_frame_clken = clken_q;
  assign per_img_Y       = y_q;
  assign frame_done      = done_q;

endmodule

// File: tb/tb_video_pattern_gen.sv
// Scoreboard bench for video_pattern_gen: two geometries share stimulus, each with a frame model.
// Honours VIDEO_PATGEN_MOVE_EN in its model of the ramp offset.
module tb_video_pattern_gen;

  typedef struct packed {
    logic [31:0] cyc;
    logic        vs;
    logic        hr;
    logic [7:0]  y;
    logic        dn;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] level = 8'd0;

  int         cyc = 0;
  bit         en_smp = 1'b0;
  bit         rst_smp = 1'b0;
  logic [1:0] mode_smp = 2'd0;
  logic [7:0] level_smp = 8'd0;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge
  always @(posedge clk) begin
    cyc       <= cyc + 1;
    en_smp    <= en;
    rst_smp   <= rst_n;
    mode_smp  <= mode;
    level_smp <= level;
  end

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int HA  = (g == 0) ? 8 : 16;
    localparam int HB  = 4;
    localparam int VS  = (g == 0) ? 2 : 1;
    localparam int VB  = (g == 0) ? 1 : 0;
    localparam int VA  = (g == 0) ? 4 : 16;
    localparam int VF  = (g == 0) ? 1 : 0;
    localparam int DIV = (g == 0) ? 1 : 3;
    localparam int HT  = HA + HB;
    localparam int VT  = VS + VB + VA + VF;

    logic       vsync, href, clken, done;
    logic [7:0] y;
    exp_t       q[$];
    exp_t       last = '0;
    exp_t       r;
    bit         idle_q = 1'b1;
    logic [7:0] offset = 8'd0;

    video_pattern_gen #(
      .H_ACTIVE(HA), .H_BLANK(HB), .V_SYNC(VS), .V_BACK(VB),
      .V_ACTIVE(VA), .V_FRONT(VF), .CLK_DIV(DIV)
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .en             (en),
      .mode           (mode),
      .level          (level),
      .per_frame_vsync(vsync),
      .per_frame_href (href),
      .per_frame_clken(clken),
      .per_img_Y      (y),
      .frame_done     (done)
    );

    // Expected ticks of one frame whose VSYNC entry happens at edge c0
    task automatic push_frame(input int c0, input logic [1:0] md, input logic [7:0] lv,
                              input logic [7:0] off);
      exp_t e;
      int   ay;
      for (int ln = 0; ln < VT; ln++) begin
        for (int h = 0; h < HT; h++) begin
          e.cyc = 32'(c0 + (ln * HT + h + 1) * DIV);
          e.vs  = (ln < VS);
          ay    = ln - VS - VB;
          e.hr  = (ay >= 0) && (ay < VA) && (h < HA);
          e.y   = 8'd0;
          if (e.hr) begin
            case (md)
              2'd0:    e.y = 8'(h) + off;
              2'd1:    e.y = 8'(ay);
              2'd2:    e.y = (((h / 8) % 2) != ((ay / 8) % 2)) ? 8'd255 : 8'd0;
              default: e.y = lv;
            endcase
          end
          e.dn = (ln == VT - 1) && (h == HT - 1);
          q.push_back(e);
        end
      end
    endtask

    always @(negedge clk) begin
      if (!rst_n || !rst_smp) begin
        q.delete();
        idle_q = 1'b1;
        offset = 8'd0;
        last   = '0;
        chk_eq($sformatf("u%0d_reset_out", g), {20'd0, vsync, href, clken, done, y}, 32'd0);
      end else if (idle_q) begin
        chk_eq($sformatf("u%0d_idle_out", g), {20'd0, vsync, href, clken, done, y}, 32'd0);
        last = '0;
        if (en_smp) begin
          push_frame(cyc, mode_smp, level_smp, offset);
          idle_q = 1'b0;
        end
      end else if (clken) begin
        if (q.size() == 0) begin
          chk_eq($sformatf("u%0d_extra_clken", g), 32'd1, 32'd0);
        end else begin
          r = q.pop_front();
          chk_eq($sformatf("u%0d_tick_cycle", g), 32'(cyc), r.cyc);
          chk_eq($sformatf("u%0d_pixel", g), {21'd0, vsync, href, y, done},
                 {21'd0, r.vs, r.hr, r.y, r.dn});
          last = r;
          if (r.dn) begin
`ifdef VIDEO_PATGEN_MOVE_EN
            offset = offset + 8'd1;
`endif
            if (en_smp) begin
              push_frame(cyc, mode_smp, level_smp, offset);
            end else begin
              idle_q = 1'b1;
            end
          end
        end
      end else begin
        chk_eq($sformatf("u%0d_hold", g), {21'd0, vsync, href, y, done},
               {21'd0, last.vs, last.hr, last.y, 1'b0});
        if (q.size() > 0 && q[0].cyc <= 32'(cyc)) begin
          chk_eq($sformatf("u%0d_missing_clken", g), 32'd0, 32'd1);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Bounded wait on instance 0: vsync falling (want_href=0) or href rising (want_href=1)
  task automatic wait_u0(input bit want_href, input string tag);
    bit prev;
    bit hit;
    prev = g_inst[0].vsync;
    hit  = 1'b0;
    for (int i = 0; i < 400 && !hit; i++) begin
      @(negedge clk);
      hit  = want_href ? g_inst[0].href : (prev && !g_inst[0].vsync);
      prev = g_inst[0].vsync;
    end
    chk_eq(tag, 32'(hit), 32'd1);
    step(1);
  endtask

  task automatic check_drained(input string tag);
    chk_eq({tag, "_u0_queue"}, 32'(g_inst[0].q.size()), 32'd0);
    chk_eq({tag, "_u1_queue"}, 32'(g_inst[1].q.size()), 32'd0);
    chk_eq({tag, "_u0_idle"}, 32'(g_inst[0].idle_q), 32'd1);
    chk_eq({tag, "_u1_idle"}, 32'(g_inst[1].idle_q), 32'd1);
  endtask

  initial begin
    step(5);
    rst_n = 1'b1;
    step(5);
    en = 1'b1;
    step(1100);
    mode = 2'd2;
    step(2200);
    mode = 2'd1;
    step(1100);
    mode = 2'd0;
    step(1100);
    wait_u0(1'b1, "wait_active_for_mode3");
    mode  = 2'd3;
    level = 8'h5A;
    step(1200);
    mode = 2'd0;
    step(200);
    wait_u0(1'b0, "wait_vback");
    en = 1'b0;
    step(1100);
    check_drained("after_en_drop");
    en = 1'b1;
    wait_u0(1'b1, "wait_active_for_reset");
    rst_n = 1'b0;
    #1;
    chk_eq("async_reset_u0", {20'd0, g_inst[0].vsync, g_inst[0].href, g_inst[0].clken,
                              g_inst[0].done, g_inst[0].y}, 32'd0);
    chk_eq("async_reset_u1", {20'd0, g_inst[1].vsync, g_inst[1].href, g_inst[1].clken,
                              g_inst[1].done, g_inst[1].y}, 32'd0);
    step(3);
    rst_n = 1'b1;
    step(300);
    en = 1'b0;
    step(1100);
    check_drained("final");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
